uvmt_cv32e40s_pma_obi_tracker: RTL and testbench

Downstream consumer of the PMA model output on one OBI port (instruction or data side). It samples the PMA status at each OBI address-phase handshake and holds it in an in-order FIFO of outstanding transactions. At each response it presents the status that applied to that transaction, so response-phase assertions can check it. It also flags bus protocol and PMA-consistency violations as registered single-cycle pulses.

---
 rtl/uvmt_cv32e40s_base_test_pkg.sv | 25 ++
 rtl/uvmt_cv32e40s_pma_obi_fifo.sv | 62 ++++++
 rtl/uvmt_cv32e40s_pma_obi_tracker.sv | 143 ++++++++++++++
 tb/tb_uvmt_cv32e40s_pma_obi_tracker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uvmt_cv32e40s_base_test_pkg.sv
// rtl/uvmt_cv32e40s_base_test_pkg.sv - shared PMA status and OBI tracker types
package uvmt_cv32e40s_base_test_pkg;

  typedef struct packed {
    logic main;
    logic bufferable;
    logic cacheable;
    logic integrity;
    logic allow;
  } pma_status_t;

  typedef struct packed {
    logic [31:0] addr;
    pma_status_t status;
    logic [1:0]  memtype;
  } pma_obi_entry_t;

  localparam int PMA_OBI_MAX_OUTSTANDING_LIMIT = 4;

  typedef enum logic {
    PMA_OBI_IDLE     = 1'b0,
    PMA_OBI_WAIT_GNT = 1'b1
  } pma_obi_phase_e;

endpackage

// File: rtl/uvmt_cv32e40s_pma_obi_fifo.sv
// rtl/uvmt_cv32e40s_pma_obi_fifo.sv - circular sync FIFO that drops pushes when full
module uvmt_cv32e40s_pma_obi_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the head slot, so a push to a full FIFO still lands.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_drop = i_push && !w_push;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uvmt_cv32e40s_pma_obi_tracker.sv
// rtl/uvmt_cv32e40s_pma_obi_tracker.sv - per-transaction PMA status tracker and OBI checks
module uvmt_cv32e40s_pma_obi_tracker
  import uvmt_cv32e40s_base_test_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit IS_INSTR_SIDE   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obi_req,
  input  logic        obi_gnt,
  input  logic [31:0] obi_addr,
  input  logic [1:0]  obi_memtype,
  input  logic        obi_rvalid,
  input  logic        obi_err,
  input  pma_status_t pma_status_i,
  output logic        rsp_valid_o,
  output pma_status_t rsp_status_o,
  output logic [31:0] rsp_addr_o,
  output logic [2:0]  outstanding_o,
  output logic        err_overflow_o,
  output logic        err_underflow_o,
  output logic        err_unstable_o,
  output logic        err_disallowed_o,
  output logic        err_memtype_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  pma_obi_phase_e r_state;
  pma_obi_phase_e w_state_nxt;
  logic [31:0]    r_lat_addr;
  logic [1:0]     r_lat_memtype;
  logic           w_lat_load;
  logic           w_unstable;

  logic           w_accept;
  logic           w_full;
  logic           w_empty;
  logic           w_drop;
  logic [CNT_W-1:0] w_count;
  pma_obi_entry_t w_wentry;
  pma_obi_entry_t w_head;
  logic           w_underflow;
  logic           w_disallowed;
  logic           w_memtype_bad;
  logic           w_unused;

  assign w_accept = obi_req && obi_gnt;
  assign w_wentry = '{addr: obi_addr, status: pma_status_i, memtype: obi_memtype};

  uvmt_cv32e40s_pma_obi_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH ($bits(pma_obi_entry_t))
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_accept),
    .i_wdata (w_wentry),
    .i_pop   (obi_rvalid),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  assign rsp_valid_o   = obi_rvalid && !w_empty;
  assign rsp_status_o  = w_empty ? '0 : w_head.status;
  assign rsp_addr_o    = w_empty ? '0 : w_head.addr;
  assign outstanding_o = 3'(w_count);

  // Response error and stored memtype don't affect tracking; full is implied by drop.
  assign w_unused = ^{obi_err, w_full, w_head.memtype};

  always_comb begin
    w_state_nxt = r_state;
    w_lat_load  = 1'b0;
    w_unstable  = 1'b0;
    case (r_state)
      PMA_OBI_IDLE: begin
        if (obi_req && !obi_gnt) begin
          w_state_nxt = PMA_OBI_WAIT_GNT;
          w_lat_load  = 1'b1;
        end
      end
      PMA_OBI_WAIT_GNT: begin
        if (!obi_req) begin
          w_state_nxt = PMA_OBI_IDLE;
          w_unstable  = 1'b1;
        end else if (obi_addr != r_lat_addr || obi_memtype != r_lat_memtype) begin
          w_unstable = 1'b1;
          if (obi_gnt) begin
            w_state_nxt = PMA_OBI_IDLE;
          end else begin
            w_lat_load = 1'b1;
          end
        end else if (obi_gnt) begin
          w_state_nxt = PMA_OBI_IDLE;
        end
      end
      default: w_state_nxt = PMA_OBI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= PMA_OBI_IDLE;
      r_lat_addr    <= '0;
      r_lat_memtype <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lat_load) begin
        r_lat_addr    <= obi_addr;
        r_lat_memtype <= obi_memtype;
      end
    end
  end

  assign w_underflow   = obi_rvalid && w_empty;
  assign w_disallowed  = w_accept && !pma_status_i.allow;
  assign w_memtype_bad = w_accept &&
                         ((obi_memtype[1] != pma_status_i.cacheable) ||
                          (obi_memtype[0] != pma_status_i.bufferable) ||
                          (IS_INSTR_SIDE && obi_memtype[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_o   <= 1'b0;
      err_underflow_o  <= 1'b0;
      err_unstable_o   <= 1'b0;
      err_disallowed_o <= 1'b0;
      err_memtype_o    <= 1'b0;
    end else begin
      err_overflow_o   <= w_drop;
      err_underflow_o  <= w_underflow;
      err_unstable_o   <= w_unstable;
      err_disallowed_o <= w_disallowed;
      err_memtype_o    <= w_memtype_bad;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40s_pma_obi_tracker.sv
// tb/tb_uvmt_cv32e40s_pma_obi_tracker.sv - scoreboard bench for the PMA OBI tracker
module tb_uvmt_cv32e40s_pma_obi_tracker;
  import uvmt_cv32e40s_base_test_pkg::*;

  localparam int MAXO = 2;
  localparam bit INSTR = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        obi_req = 1'b0;
  logic        obi_gnt = 1'b0;
  logic [31:0] obi_addr = '0;
  logic [1:0]  obi_memtype = '0;
  logic        obi_rvalid = 1'b0;
  logic        obi_err = 1'b0;
  pma_status_t pma_status_i = '0;
  logic        rsp_valid_o;
  pma_status_t rsp_status_o;
  logic [31:0] rsp_addr_o;
  logic [2:0]  outstanding_o;
  logic        err_overflow_o, err_underflow_o, err_unstable_o, err_disallowed_o, err_memtype_o;

  uvmt_cv32e40s_pma_obi_tracker #(.MAX_OUTSTANDING(MAXO), .IS_INSTR_SIDE(INSTR)) dut (
    .clk(clk), .rst_n(rst_n), .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr),
    .obi_memtype(obi_memtype), .obi_rvalid(obi_rvalid), .obi_err(obi_err),
    .pma_status_i(pma_status_i), .rsp_valid_o(rsp_valid_o), .rsp_status_o(rsp_status_o),
    .rsp_addr_o(rsp_addr_o), .outstanding_o(outstanding_o), .err_overflow_o(err_overflow_o),
    .err_underflow_o(err_underflow_o), .err_unstable_o(err_unstable_o),
    .err_disallowed_o(err_disallowed_o), .err_memtype_o(err_memtype_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: transactions the model says are outstanding, oldest first.
  pma_obi_entry_t exp_q[$];
  logic [4:0]     exp_err = '0;   // {overflow, underflow, unstable, disallowed, memtype}
  int             exp_cnt = 0;

  // Reference model state, advanced once per driven cycle.
  int             m_cnt = 0;
  logic           ph_pend = 1'b0;
  logic [31:0]    ph_addr = '0;
  logic [1:0]     ph_mt = '0;
  logic           pend_push = 1'b0;
  pma_obi_entry_t pend_entry = '0;
  logic [4:0]     pend_err = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic empty;
    empty = (exp_q.size() == 0);
    chk("rsp_valid", 64'(rsp_valid_o), 64'(obi_rvalid && !empty));
    chk("rsp_addr", 64'(rsp_addr_o), empty ? 64'd0 : 64'(exp_q[0].addr));
    chk("rsp_status", 64'(rsp_status_o), empty ? 64'd0 : 64'(exp_q[0].status));
    chk("outstanding", 64'(outstanding_o), 64'(exp_cnt));
    chk("err_flags", 64'({err_overflow_o, err_underflow_o, err_unstable_o,
                          err_disallowed_o, err_memtype_o}), 64'(exp_err));
    if (obi_rvalid && !empty) void'(exp_q.pop_front());
  end

  function automatic pma_status_t mk_st(input logic main, input logic bufb,
                                        input logic cach, input logic allow);
    pma_status_t s;
    s = '0;
    s.main = main; s.bufferable = bufb; s.cacheable = cach; s.allow = allow;
    return s;
  endfunction

  task automatic cyc(input logic req, input logic gnt, input logic [31:0] addr,
                     input logic [1:0] mt, input pma_status_t st, input logic rv);
    logic acc, pop, ovf, unf, unst, dis, mtb;
    @(posedge clk);
    if (pend_push) exp_q.push_back(pend_entry);
    exp_err = pend_err;
    exp_cnt = m_cnt;
    #1;
    obi_req = req; obi_gnt = gnt; obi_addr = addr; obi_memtype = mt;
    pma_status_i = st; obi_rvalid = rv; obi_err = $urandom_range(0, 1);
    acc  = req && gnt;
    pop  = rv && (m_cnt > 0);
    unf  = rv && (m_cnt == 0);
    ovf  = acc && (m_cnt == MAXO) && !pop;
    unst = ph_pend && (!req || addr != ph_addr || mt != ph_mt);
    dis  = acc && !st.allow;
    mtb  = acc && (mt[1] != st.cacheable || mt[0] != st.bufferable || (INSTR && mt[0]));
    pend_push  = acc && !ovf;
    pend_entry = '{addr: addr, status: st, memtype: mt};
    pend_err   = {ovf, unf, unst, dis, mtb};
    m_cnt = m_cnt + int'(pend_push) - int'(pop);
    ph_pend = req && !gnt;
    if (ph_pend) begin ph_addr = addr; ph_mt = mt; end
  endtask

  task automatic idle(input int n, input logic rv);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 2'b00, '0, rv);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    obi_req = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_addr = '0;
    obi_memtype = '0; pma_status_i = '0;
    exp_q.delete(); exp_err = '0; exp_cnt = 0;
    m_cnt = 0; ph_pend = 1'b0; pend_push = 1'b0; pend_err = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    pma_status_t st;
    logic [31:0] a;
    logic [1:0]  mt;
    logic        rq;
    do_reset();

    // Single transaction, response three cycles after the accept.
    st = mk_st(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'h0000_1000, 2'b00, st, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Back-to-back accepts, third accept alongside the first response.
    cyc(1'b1, 1'b1, 32'h100, 2'b00, st, 1'b0);
    cyc(1'b1, 1'b1, 32'h200, 2'b00, mk_st(1'b0, 1'b0, 1'b1, 1'b1), 1'b0);
    cyc(1'b1, 1'b1, 32'h300, 2'b10, mk_st(1'b0, 1'b0, 1'b1, 1'b1), 1'b1);
    idle(2, 1'b1);
    idle(1, 1'b0);

    // Overflow at full occupancy.
    cyc(1'b1, 1'b1, 32'h400, 2'b00, st, 1'b0);
    cyc(1'b1, 1'b1, 32'h404, 2'b00, st, 1'b0);
    cyc(1'b1, 1'b1, 32'h408, 2'b00, st, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Address changed, then request withdrawn, before grant.
    cyc(1'b1, 1'b0, 32'h40, 2'b00, st, 1'b0);
    cyc(1'b1, 1'b0, 32'h44, 2'b00, st, 1'b0);
    cyc(1'b0, 1'b0, 32'h44, 2'b00, st, 1'b0);
    idle(2, 1'b0);

    // Memtype mismatch and disallowed together.
    cyc(1'b1, 1'b1, 32'h800, 2'b01, mk_st(1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);

    // Reset with two outstanding, then an unmatched response.
    cyc(1'b1, 1'b1, 32'h900, 2'b00, st, 1'b0);
    cyc(1'b1, 1'b1, 32'h904, 2'b00, st, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(1, 1'b1);
    idle(2, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      st = pma_status_t'($urandom_range(0, 31));
      st.allow = ($urandom_range(0, 7) != 0);
      if (ph_pend && $urandom_range(0, 19) != 0) begin
        rq = 1'b1; a = ph_addr; mt = ph_mt;
      end else begin
        rq = ($urandom_range(0, 3) != 0);
        a  = {$urandom_range(0, 15), 4'h0};
        mt = ($urandom_range(0, 4) != 0) ? {st.cacheable, st.bufferable}
                                         : 2'($urandom_range(0, 3));
      end
      cyc(rq, 1'($urandom_range(0, 1)), a, mt, st, ($urandom_range(0, 2) == 0));
    end
    idle(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
